// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit seven-segment display arbiter.
// Segment bit set = segment lit (common cathode).
package seg_pkg;

  localparam logic [8:0] SEG_BLANK = 9'h000;
  localparam logic [8:0] SEG_DASH  = 9'h040;

  localparam logic [8:0] SEG_DIGIT [0:9] = '{
    9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
    9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f
  };

  typedef enum logic [1:0] {
    SHOW_CNT = 2'd0,
    SHOW_MSG = 2'd1,
    GAP      = 2'd2
  } state_e;

  // Anything outside 0..9 decodes to blank rather than garbage.
  function automatic logic [8:0] digit_code(input logic [6:0] d);
    digit_code = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == 7'(i)) digit_code = SEG_DIGIT[i];
    end
  endfunction

endpackage

// File: rtl/seg_encode.sv
// Combinational 7-bit value to {tens, ones} segment patterns.
// 100..127 show dashes; optional leading-zero blanking for 0..9.
module seg_encode
  import seg_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic [6:0] value_i,
  output logic [8:0] tens_o,
  output logic [8:0] ones_o
);

  logic [6:0] tens_w;
  logic [6:0] ones_w;

  assign tens_w = value_i / 7'd10;
  assign ones_w = value_i % 7'd10;

  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    tens_o = digit_code(tens_w);
    ones_o = digit_code(ones_w);
    if (value_i > 7'd99) begin
      tens_o = SEG_DASH;
      ones_o = SEG_DASH;
    end else if (LZ_BLANK && (value_i < 7'd10)) begin
      tens_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the two-digit display between the tap counter (default owner) and a
// timed message source with optional blink, followed by a blank gap.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 24_000_000,
  parameter int unsigned BLINK_CYCLES = 3_000_000,
  parameter int unsigned GAP_CYCLES   = 1_200_000,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cnt_value,
  input  logic       msg_valid,
  input  logic [6:0] msg_data,
  input  logic       msg_blink,
  output logic       msg_ready,
  input  logic       msg_cancel,
  output logic [8:0] seg0,
  output logic [8:0] seg1,
  output logic       disp_owner
);

  localparam int unsigned MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int unsigned PW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] BLINK_LOAD = PW'(BLINK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    msg_data_q, msg_data_d;
  logic          msg_blink_q, msg_blink_d;
  logic [8:0]    seg0_q, seg0_d;
  logic [8:0]    seg1_q, seg1_d;
  logic          owner_q, owner_d;

  logic [6:0]    enc_value;
  logic [8:0]    enc_tens;
  logic [8:0]    enc_ones;

  assign msg_ready = (state_q == SHOW_CNT);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    phase_cnt_d = phase_cnt_q;
    phase_d     = phase_q;
    msg_data_d  = msg_data_q;
    msg_blink_d = msg_blink_q;
    case (state_q)
      SHOW_CNT: begin
        // Cancel is meaningless here, even alongside an accepted request.
        if (msg_valid) begin
          state_d     = SHOW_MSG;
          timer_d     = HOLD_LOAD;
          msg_data_d  = msg_data;
          msg_blink_d = msg_blink;
          phase_cnt_d = BLINK_LOAD;
          phase_d     = 1'b0;
        end
      end
      SHOW_MSG: begin
        if (phase_cnt_q == '0) begin
          phase_cnt_d = BLINK_LOAD;
          phase_d     = ~phase_q;
        end else begin
          phase_cnt_d = phase_cnt_q - 1'b1;
        end
        if (msg_cancel) begin
          state_d = SHOW_CNT;
        end else if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (msg_cancel || (timer_q == '0)) begin
          state_d = SHOW_CNT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = SHOW_CNT;
    endcase
  end

  assign enc_value = (state_q == SHOW_MSG) ? msg_data_q : cnt_value;

  seg_encode #(.LZ_BLANK(LZ_BLANK)) u_encode (
    .value_i (enc_value),
    .tens_o  (enc_tens),
    .ones_o  (enc_ones)
  );

  always_comb begin
    seg1_d  = enc_tens;
    seg0_d  = enc_ones;
    owner_d = 1'b0;
    case (state_q)
      SHOW_MSG: begin
        owner_d = 1'b1;
        if (msg_blink_q && phase_q) begin
          seg1_d = SEG_BLANK;
          seg0_d = SEG_BLANK;
        end
      end
      GAP: begin
        owner_d = 1'b1;
        seg1_d  = SEG_BLANK;
        seg0_d  = SEG_BLANK;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SHOW_CNT;
      timer_q     <= '0;
      phase_cnt_q <= '0;
      phase_q     <= 1'b0;
      msg_data_q  <= '0;
      msg_blink_q <= 1'b0;
      seg0_q      <= SEG_BLANK;
      seg1_q      <= SEG_BLANK;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phase_cnt_q <= phase_cnt_d;
      phase_q     <= phase_d;
      msg_data_q  <= msg_data_d;
      msg_blink_q <= msg_blink_d;
      seg0_q      <= seg0_d;
      seg1_q      <= seg1_d;
      owner_q     <= owner_d;
    end
  end

  assign seg0       = seg0_q;
  assign seg1       = seg1_q;
  assign disp_owner = owner_q;

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Sequential arbiter that shares the two-digit 9-bit 7-segment display pair (seg1 = tens, seg0 = ones, common-cathode, bit set = segment on) between two requesters. The first requester is the tap counter's running value, which owns the display by default. The second is a message source whose value is shown for a fixed hold time, optionally blinking, followed by a blank gap. It sits between the counter/message logic and the board display pins and replaces direct digit decoding in the top level.

## Interface
- HOLD_CYCLES, 24_000_000 — cycles a message owns the display (2 s at 12 MHz); ≥1
- BLINK_CYCLES, 3_000_000 — blink half-period in cycles; ≥1
- GAP_CYCLES, 1_200_000 — blank cycles after a message before the counter regains the display; ≥1
- LZ_BLANK, 1 — 1: blank the tens digit for values 0–9
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cnt_value  in  7  counter value (default requester)
- msg_valid  in  1  message request
- msg_data  in  7  message value
- msg_blink  in  1  blink enable, qualified by msg_valid
- msg_ready  out  1  arbiter can accept a message
- msg_cancel  in  1  abort current message/gap
- seg0  out  9  ones-digit segment pattern
- seg1  out  9  tens-digit segment pattern
- disp_owner  out  1  0 = counter shown, 1 = message/gap shown

## Operation
- States: SHOW_CNT, SHOW_MSG, GAP. Reset state: SHOW_CNT.
- msg_ready = (state == SHOW_CNT), combinational from state.
- Handshake: on a clock edge with msg_valid & msg_ready, latch msg_data and msg_blink, load the timer with HOLD_CYCLES−1, and go to SHOW_MSG. The source holds msg_valid/msg_data until accepted. Requests outside SHOW_CNT are ignored and not queued.
- SHOW_MSG: decrement the timer each cycle. At 0, load GAP_CYCLES−1 and go to GAP.
- GAP: decrement the timer each cycle. At 0, go to SHOW_CNT.
- msg_cancel in SHOW_MSG or GAP: next state is SHOW_CNT, and it wins over timer expiry. msg_cancel in SHOW_CNT has no effect, even when it coincides with an accepted message.
- Value encoding, applied to cnt_value and to the latched message:
  - v = 0..99: seg1 = digit(v/10), seg0 = digit(v%10).
  - If LZ_BLANK and v < 10: seg1 = SEG_BLANK.
  - v = 100..127: both digits = SEG_DASH (9'h040).
- Digit codes: 0:3f, 1:06, 2:5b, 3:4f, 4:66, 5:6d, 6:7d, 7:07, 8:7f, 9:6f. Blank = 9'h000.
- Output selection:
  - SHOW_CNT → encode(cnt_value).
  - SHOW_MSG → encode(message). If blink is latched, show blank when (elapsed/BLINK_CYCLES) is odd. Elapsed = cycles since entry, starting at 0. Track it with a separate phase counter that reloads every BLINK_CYCLES and toggles a phase bit.
  - GAP → both blank.
- disp_owner = 1 whenever the outputs come from SHOW_MSG or GAP.

## Timing
- seg0, seg1 and disp_owner are registered. Reset values: 9'h000, 9'h000, 0.
- Outputs are computed from current state and live cnt_value. A cnt_value change at edge n is visible after edge n+1; latency is 1 cycle.
- Message accepted at edge k: state = SHOW_MSG after k, and the message is visible after k+1. The message is visible for exactly HOLD_CYCLES cycles, then blank for GAP_CYCLES cycles, then the counter is shown.
- Cancel sampled at edge c: the counter is visible after c+1.
- Reset asserted mid-message: immediate return to SHOW_CNT with blank outputs. The message is lost. After release, the first edge shows the counter.
- Timers are $clog2(max(HOLD_CYCLES, GAP_CYCLES)) bits wide and do not wrap or underflow.

## Structure
- Package seg_pkg:
  - SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH constants
  - state enum {SHOW_CNT, SHOW_MSG, GAP}
- Sub-module seg_encode:
  - combinational 7-bit value plus LZ_BLANK → {tens, ones} 9-bit patterns
  - instantiated once, fed by a value mux (cnt_value vs latched message)
- Top: FSM, hold/gap timer, blink phase counter, output registers.

## Test plan
All scenarios use HOLD_CYCLES=10, BLINK_CYCLES=2, GAP_CYCLES=3, LZ_BLANK=1.
1. Reset, then cnt_value=42 → seg1=9'h066, seg0=9'h05b, disp_owner=0 one cycle later. cnt_value=7 → seg1=9'h000, seg0=9'h007. cnt_value=100 → both 9'h040.
2. msg_valid with msg_data=99, blink=0 in SHOW_CNT → msg_ready drops. Both digits 9'h06f for exactly 10 cycles, then 9'h000 for 3 cycles, then the counter returns; msg_ready rises with the counter.
3. Message 5 with blink=1 → seg0 sequence 9'h06d ×2, blank ×2, repeating for 10 cycles. seg1 stays blank throughout.
4. Second msg_valid during SHOW_MSG/GAP → ignored. Held valid is accepted on the first SHOW_CNT cycle.
5. msg_cancel on hold cycle 4, and separately on the final hold cycle → counter visible the next cycle in both cases, with no gap.
6. rst low during GAP → outputs 9'h000, disp_owner=0 immediately. After release, the counter is displayed and msg_ready=1.
